// File: rtl/mul3_pipe.sv
// Three-stage pipelined a*b*c multiplier with a global valid/ready stall, an optional
// rounding right shift and saturation to OUT_W bits. A sideband tag travels with each operand set.
module mul3_pipe #(
  parameter int A_W    = 18,
  parameter int B_W    = 10,
  parameter int C_W    = 10,
  parameter int SIGNED = 0,
  parameter int SHIFT  = 0,
  parameter int ROUND  = 0,
  parameter int OUT_W  = 38,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic [C_W-1:0]   c,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic [TAG_W-1:0] tag_out,
  output logic             overflow
);

  localparam int BC_W    = B_W + C_W;
  localparam int P_W     = A_W + BC_W;
  localparam int HI_W    = P_W + 2 - OUT_W;
  localparam int RND_POS = (SHIFT > 0) ? (SHIFT - 1) : 0;
  localparam logic [P_W:0] ONE = {{P_W{1'b0}}, 1'b1};
  localparam logic [P_W:0] RND = ((ROUND != 0) && (SHIFT > 0)) ? (ONE << RND_POS) : {(P_W+1){1'b0}};

  // Returns {overflow, clamped result}; the top bits of r must all match the kept sign (or be zero).
  function automatic logic [OUT_W:0] saturate(input logic [P_W:0] r);
    logic [HI_W-1:0] hi;
    logic [OUT_W:0]  res;
    hi = r[P_W:OUT_W-1];
    if (SIGNED != 0) begin
      if ((&hi) || !(|hi)) begin
        res = {1'b0, r[OUT_W-1:0]};
      end else if (r[P_W]) begin
        res = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        res = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
      end
    end else begin
      if (|hi[HI_W-1:1]) begin
        res = {1'b1, {OUT_W{1'b1}}};
      end else begin
        res = {1'b0, r[OUT_W-1:0]};
      end
    end
    return res;
  endfunction

  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [A_W-1:0]   a1_q, a1_d;
  logic [BC_W-1:0]  p0_q, p0_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
  logic [P_W-1:0]   p1_q, p1_d;
  logic [OUT_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;

  logic             en;
  logic             b_sx, c_sx, a_sx, p0_sx, p1_sx;
  logic [BC_W-1:0]  b_ext, c_ext;
  logic [P_W-1:0]   p0_ext, a_ext;
  logic [P_W:0]     sum, r;
  logic [OUT_W:0]   sat;

  assign en        = !v3_q || out_ready;
  assign in_ready  = en && !rst;
  assign out_valid = v3_q;
  assign result    = result_q;
  assign tag_out   = tag3_q;
  assign overflow  = ovf_q;

  // Operand extension and the three stage datapaths; each stage loads only when it receives a valid item.
  always_comb begin
    b_sx   = (SIGNED != 0) && b[B_W-1];
    c_sx   = (SIGNED != 0) && c[C_W-1];
    a_sx   = (SIGNED != 0) && a1_q[A_W-1];
    p0_sx  = (SIGNED != 0) && p0_q[BC_W-1];
    p1_sx  = (SIGNED != 0) && p1_q[P_W-1];
    b_ext  = {{C_W{b_sx}}, b};
    c_ext  = {{B_W{c_sx}}, c};
    p0_ext = {{A_W{p0_sx}}, p0_q};
    a_ext  = {{BC_W{a_sx}}, a1_q};
    sum    = {p1_sx, p1_q} + RND;
    if (SIGNED != 0) begin
      r = $signed(sum) >>> SHIFT;
    end else begin
      r = sum >> SHIFT;
    end
    sat = saturate(r);

    if (en) begin
      v1_d = in_valid;
      v2_d = v1_q;
      v3_d = v2_q;
    end else begin
      v1_d = v1_q;
      v2_d = v2_q;
      v3_d = v3_q;
    end

    if (en && in_valid) begin
      p0_d   = b_ext * c_ext;
      a1_d   = a;
      tag1_d = tag_in;
    end else begin
      p0_d   = p0_q;
      a1_d   = a1_q;
      tag1_d = tag1_q;
    end

    if (en && v1_q) begin
      p1_d   = p0_ext * a_ext;
      tag2_d = tag1_q;
    end else begin
      p1_d   = p1_q;
      tag2_d = tag2_q;
    end

    if (en && v2_q) begin
      result_d = sat[OUT_W-1:0];
      ovf_d    = sat[OUT_W];
      tag3_d   = tag2_q;
    end else begin
      result_d = result_q;
      ovf_d    = ovf_q;
      tag3_d   = tag3_q;
    end
  end

  // Pipeline registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      a1_q     <= '0;
      p0_q     <= '0;
      tag1_q   <= '0;
      p1_q     <= '0;
      tag2_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      tag3_q   <= '0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      a1_q     <= a1_d;
      p0_q     <= p0_d;
      tag1_q   <= tag1_d;
      p1_q     <= p1_d;
      tag2_q   <= tag2_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      tag3_q   <= tag3_d;
    end
  end

endmodule
